// File: rtl/arb_pkg.sv
// Shared constants and FSM state type for the four-way round-robin arbiter.
package arb_pkg;

  localparam int unsigned NREQ  = 4;
  localparam int unsigned SEL_W = 2;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } arb_state_e;

endpackage

// File: rtl/mux_arbiter4_if.sv
// Request/grant bundle between the requesting units (master) and the arbiter (slave).
interface mux_arbiter4_if;
  import arb_pkg::*;

  logic [NREQ-1:0]  Req;
  logic             Done;
  logic [NREQ-1:0]  Gnt;
  logic [SEL_W-1:0] Sel;
  logic             Valid;
  logic             Timeout;

  modport master (
    output Req, Done,
    input  Gnt, Sel, Valid, Timeout
  );

  modport slave (
    input  Req, Done,
    output Gnt, Sel, Valid, Timeout
  );

endinterface

// File: rtl/rr_pick4.sv
// Combinational round-robin pick: scans last+1 .. last+4 (mod 4), first set Req wins.
module rr_pick4
  import arb_pkg::*;
(
  input  logic [NREQ-1:0]  Req,
  input  logic [SEL_W-1:0] last,
  output logic             any,
  output logic [SEL_W-1:0] win,
  output logic [NREQ-1:0]  win_oh
);

  logic             found;
  logic [SEL_W-1:0] idx;

  always_comb begin
    any    = |Req;
    win    = last;
    win_oh = '0;
    found  = 1'b0;
    idx    = last;
    for (int i = 1; i <= 4; i++) begin
      idx = last + SEL_W'(i);
      if (!found && Req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
    if (found) win_oh = NREQ'(1) << win;
  end

endmodule

// File: rtl/mux_arbiter4.sv
// Round-robin arbiter driving the 4:1 datapath mux select, with per-grant hold watchdog.
module mux_arbiter4
  import arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic           CLK,
  input  logic           Reset,
  mux_arbiter4_if.slave  bus
);

  localparam int unsigned CNT_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

  arb_state_e       state_q, state_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [SEL_W-1:0] last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             valid_q, valid_d;
  logic             timeout_q, timeout_d;

  logic             pick_any;
  logic [SEL_W-1:0] pick_win;
  logic [NREQ-1:0]  pick_oh;
  logic             wd_hit, abort, rel;

  rr_pick4 u_pick (
    .Req    (bus.Req),
    .last   (last_q),
    .any    (pick_any),
    .win    (pick_win),
    .win_oh (pick_oh)
  );

  assign wd_hit = (cnt_q == CNT_W'(MAX_HOLD - 1));
  assign abort  = ~|(bus.Req & gnt_q);
  assign rel    = bus.Done | abort | wd_hit;

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      sel_q     <= '0;
      last_q    <= SEL_W'(NREQ - 1);
      cnt_q     <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      sel_q     <= sel_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
    end
  end

  // Next-state: a release either hands over directly to the next winner or drops to IDLE.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    sel_d     = sel_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          gnt_d   = pick_oh;
          sel_d   = pick_win;
          last_d  = pick_win;
          cnt_d   = '0;
          state_d = OWN;
        end
      end
      OWN: begin
        if (rel) begin
          timeout_d = wd_hit & ~bus.Done;
          cnt_d     = '0;
          if (pick_any) begin
            gnt_d  = pick_oh;
            sel_d  = pick_win;
            last_d = pick_win;
          end else begin
            gnt_d   = '0;
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    valid_d = |gnt_d;
  end

  assign bus.Gnt     = gnt_q;
  assign bus.Sel     = sel_q;
  assign bus.Valid   = valid_q;
  assign bus.Timeout = timeout_q;

endmodule
